// File: rtl/ip_tx_pkg.sv
// Shared constants and the FSM state type for the wide IPv4 transmitter.
package ip_tx_pkg;

  localparam logic [15:0] ETH_TYPE       = 16'h8000;
  localparam logic [7:0]  IP_VERSION_IHL = 8'h45;
  localparam logic [7:0]  IP_TTL         = 8'h80;
  localparam logic [7:0]  IP_PROTOCOL    = 8'h04;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int IP_HDR_BYTES    = 20;
  localparam int MIN_FRAME_BYTES = 60;

  // Header words summed by the checksum, and the smallest payload that
  // still reaches the minimum frame size.
  localparam int CSUM_WORDS        = IP_HDR_BYTES / 2;
  localparam int HDR_BYTES         = ETH_HDR_BYTES + IP_HDR_BYTES;
  localparam int MIN_PAYLOAD_BYTES = MIN_FRAME_BYTES - HDR_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CSUM,
    ST_FOLD,
    ST_SEND
  } state_e;

endpackage

// File: rtl/ip_header_checksum_seq.sv
// Sequential IPv4 header checksum: one 16-bit word per cycle into a
// 32-bit accumulator, then a single fold/invert cycle that raises done.
module ip_header_checksum_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] csum,
  output logic        done
);

  logic [31:0] acc;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Two end-around folds; the second can never carry again.
  always_comb begin
    fold1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    fold2 = fold1[15:0] + {15'd0, fold1[16]};
  end

  // Accumulate, then capture the inverted folded sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      csum <= '0;
      done <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      done <= 1'b0;
    end else if (add) begin
      acc <= acc + {16'd0, word};
    end else if (fold) begin
      csum <= ~fold2;
      done <= 1'b1;
    end
  end

endmodule

// File: rtl/ip_packet_tx_wide.sv
// Ethernet II + IPv4 frame transmitter with a DATA_BYTES-wide MAC stream.
// Optional feature macro: IP_TX_IDENT_COUNTER_EN (per-frame identification
// counter; when undefined the identification field is 0x0000).
//
// MAC stream handshake: a beat transfers on a rising edge where
// MAC_DATA_VALID and MAC_DATA_READY are both 1; while VALID=1 and READY=0
// the beat (DATA, KEEP, LAST) is held unchanged, and VALID never drops
// between the first and the LAST beat of a frame.
module ip_packet_tx_wide
  import ip_tx_pkg::*;
#(
  parameter int DATA_BYTES    = 1,
  parameter int PAYLOAD_BYTES = 2
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [31:0]                ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0]                RECIPIENT_IP_ADDRESS,
  input  logic [47:0]                RECIPIENT_MAC_ADDRESS,
  input  logic [PAYLOAD_BYTES*8-1:0] RECIPIENT_MESSAGE,
  input  logic                       START_IP_TXN,
  output logic                       READY_FOR_SEND,
  output logic [DATA_BYTES*8-1:0]    MAC_DATA_OUT,
  output logic [DATA_BYTES-1:0]      MAC_DATA_KEEP,
  input  logic                       MAC_DATA_READY,
  output logic                       MAC_DATA_VALID,
  output logic                       MAC_DATA_LAST,
  output logic                       MAC_DATA_TUSER,
  output state_e                     fsm_state
);

  localparam int PADDED_BYTES = (PAYLOAD_BYTES > MIN_PAYLOAD_BYTES) ?
                                PAYLOAD_BYTES : MIN_PAYLOAD_BYTES;
  localparam int FRAME_BYTES  = HDR_BYTES + PADDED_BYTES;
  localparam int NUM_BEATS    = (FRAME_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam logic [15:0] IP_TOTAL_LEN = 16'(IP_HDR_BYTES + PADDED_BYTES);

  state_e                     state;
  logic [47:0]                dst_mac_q;
  logic [47:0]                src_mac_q;
  logic [31:0]                dst_ip_q;
  logic [31:0]                src_ip_q;
  logic [PAYLOAD_BYTES*8-1:0] msg_q;
  logic [3:0]                 word_idx;
  logic [15:0]                beat_idx;
  logic [15:0]                ident;
  logic [15:0]                csum_word;
  logic [15:0]                csum;
  logic                       csum_done;
  logic [DATA_BYTES*8-1:0]    beat_data;
  logic [DATA_BYTES-1:0]      beat_keep;
  logic                       beat_last;

  assign MAC_DATA_TUSER = 1'b0;
  assign fsm_state      = state;

`ifdef IP_TX_IDENT_COUNTER_EN
  logic frame_done;
  assign frame_done = (state == ST_SEND) && MAC_DATA_VALID &&
                      MAC_DATA_READY && MAC_DATA_LAST;

  // Identification advances once per completed frame.
  always_ff @(posedge ACLK) begin
    if (ARESET) ident <= 16'h0000;
    else if (frame_done) ident <= ident + 16'd1;
  end
`else
  assign ident = 16'h0000;
`endif

  // Select the header word being summed this cycle (checksum field as 0).
  always_comb begin
    csum_word = 16'h0000;
    case (word_idx)
      4'd0: csum_word = {IP_VERSION_IHL, 8'h00};
      4'd1: csum_word = IP_TOTAL_LEN;
      4'd2: csum_word = ident;
      4'd4: csum_word = {IP_TTL, IP_PROTOCOL};
      4'd6: csum_word = {src_ip_q[7:0], src_ip_q[15:8]};
      4'd7: csum_word = {src_ip_q[23:16], src_ip_q[31:24]};
      4'd8: csum_word = {dst_ip_q[7:0], dst_ip_q[15:8]};
      4'd9: csum_word = {dst_ip_q[23:16], dst_ip_q[31:24]};
      default: csum_word = 16'h0000;
    endcase
  end

  ip_header_checksum_seq u_csum (
    .clk   (ACLK),
    .rst   (ARESET),
    .clear (state == ST_LATCH),
    .add   (state == ST_CSUM),
    .fold  (state == ST_FOLD),
    .word  (csum_word),
    .csum  (csum),
    .done  (csum_done)
  );

  // Byte i of the frame from the latched request.
  function automatic logic [7:0] frame_byte(input int i);
    logic [7:0] b;
    b = 8'h00;
    if (i < 6)       b = dst_mac_q[8*i +: 8];
    else if (i < 12) b = src_mac_q[8*(i-6) +: 8];
    else if (i < 26) begin
      case (i)
        12: b = ETH_TYPE[15:8];
        13: b = ETH_TYPE[7:0];
        14: b = IP_VERSION_IHL;
        16: b = IP_TOTAL_LEN[15:8];
        17: b = IP_TOTAL_LEN[7:0];
        18: b = ident[15:8];
        19: b = ident[7:0];
        22: b = IP_TTL;
        23: b = IP_PROTOCOL;
        24: b = csum[15:8];
        25: b = csum[7:0];
        default: b = 8'h00;
      endcase
    end
    else if (i < 30) b = src_ip_q[8*(i-26) +: 8];
    else if (i < HDR_BYTES) b = dst_ip_q[8*(i-30) +: 8];
    else if (i < HDR_BYTES + PAYLOAD_BYTES)
      b = msg_q[8*(PAYLOAD_BYTES-1-(i-HDR_BYTES)) +: 8];
    return b;
  endfunction

  // Assemble the beat at beat_idx; lanes past the frame end stay zero.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (int'(beat_idx) * DATA_BYTES + k < FRAME_BYTES) begin
        beat_keep[k]        = 1'b1;
        beat_data[8*k +: 8] = frame_byte(int'(beat_idx) * DATA_BYTES + k);
      end
    end
    beat_last = (beat_idx == 16'(NUM_BEATS - 1));
  end

  // Main FSM: latch request, sum header, fold, then stream beats.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= ST_IDLE;
      READY_FOR_SEND <= 1'b1;
      MAC_DATA_VALID <= 1'b0;
      MAC_DATA_LAST  <= 1'b0;
      MAC_DATA_OUT   <= '0;
      MAC_DATA_KEEP  <= '0;
      word_idx       <= '0;
      beat_idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START_IP_TXN) begin
            src_ip_q       <= ACCELERATOR_IP_ADDRESS;
            src_mac_q      <= ACCELERATOR_MAC_ADDRESS;
            dst_ip_q       <= RECIPIENT_IP_ADDRESS;
            dst_mac_q      <= RECIPIENT_MAC_ADDRESS;
            msg_q          <= RECIPIENT_MESSAGE;
            READY_FOR_SEND <= 1'b0;
            state          <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          word_idx <= '0;
          state    <= ST_CSUM;
        end
        ST_CSUM: begin
          word_idx <= word_idx + 4'd1;
          if (word_idx == 4'(CSUM_WORDS - 1)) state <= ST_FOLD;
        end
        ST_FOLD: begin
          beat_idx <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (!MAC_DATA_VALID) begin
            if (csum_done) begin
              MAC_DATA_OUT   <= beat_data;
              MAC_DATA_KEEP  <= beat_keep;
              MAC_DATA_LAST  <= beat_last;
              MAC_DATA_VALID <= 1'b1;
              beat_idx       <= beat_idx + 16'd1;
            end
          end else if (MAC_DATA_READY) begin
            if (MAC_DATA_LAST) begin
              MAC_DATA_VALID <= 1'b0;
              MAC_DATA_LAST  <= 1'b0;
              MAC_DATA_OUT   <= '0;
              MAC_DATA_KEEP  <= '0;
              READY_FOR_SEND <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              MAC_DATA_OUT  <= beat_data;
              MAC_DATA_KEEP <= beat_keep;
              MAC_DATA_LAST <= beat_last;
              beat_idx      <= beat_idx + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_packet_tx_wide.sv
// Bench for ip_packet_tx_wide: a 1-byte/2-byte-payload instance and a
// 4-byte/40-byte-payload instance, checked against a frame-level model.
module tb_ip_packet_tx_wide;
  import ip_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0]  sip, dip;
  logic [47:0]  smac, dmac;
  logic [15:0]  msg_a;
  logic [319:0] msg_b;
  logic start_a, start_b, ready_a, ready_b;

  logic        rfs_a, valid_a, last_a, tuser_a;
  logic [7:0]  data_a;
  logic [0:0]  keep_a;
  state_e      state_a;
  logic        rfs_b, valid_b, last_b, tuser_b;
  logic [31:0] data_b;
  logic [3:0]  keep_b;
  state_e      state_b;

  ip_packet_tx_wide #(.DATA_BYTES(1), .PAYLOAD_BYTES(2)) dut_a (
    .ACLK(clk), .ARESET(rst),
    .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac),
    .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac),
    .RECIPIENT_MESSAGE(msg_a), .START_IP_TXN(start_a),
    .READY_FOR_SEND(rfs_a), .MAC_DATA_OUT(data_a), .MAC_DATA_KEEP(keep_a),
    .MAC_DATA_READY(ready_a), .MAC_DATA_VALID(valid_a),
    .MAC_DATA_LAST(last_a), .MAC_DATA_TUSER(tuser_a), .fsm_state(state_a)
  );

  ip_packet_tx_wide #(.DATA_BYTES(4), .PAYLOAD_BYTES(40)) dut_b (
    .ACLK(clk), .ARESET(rst),
    .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac),
    .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac),
    .RECIPIENT_MESSAGE(msg_b), .START_IP_TXN(start_b),
    .READY_FOR_SEND(rfs_b), .MAC_DATA_OUT(data_b), .MAC_DATA_KEEP(keep_b),
    .MAC_DATA_READY(ready_b), .MAC_DATA_VALID(valid_b),
    .MAC_DATA_LAST(last_b), .MAC_DATA_TUSER(tuser_b), .fsm_state(state_b)
  );

  // ---------------- scoreboard / model state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] msg_q[$];
  int passed = 0;
  int total  = 0;
  logic [15:0] exp_ident, exp_ident_b;

  int r_lat, r_lasts, r_last_pos, r_stall_err, r_beats, r_keep_err;
  logic r_rfs_busy, r_rfs_after, r_valid_after, r_done;
  logic [3:0]  r_last_keep;
  logic [15:0] r_last_upper;

  // Frame model built straight from the frame layout rules.
  task automatic build_expected(input logic [15:0] ident);
    int p;
    int unsigned s, tl;
    logic [7:0]  hdr[34];
    logic [47:0] t48;
    logic [31:0] t32;
    logic [15:0] cs;
    p  = (msg_q.size() > 26) ? msg_q.size() : 26;
    tl = 20 + p;
    for (int i = 0; i < 6; i++) begin
      t48 = dmac >> (8*i); hdr[i]     = t48[7:0];
      t48 = smac >> (8*i); hdr[6 + i] = t48[7:0];
    end
    hdr[12] = 8'h80; hdr[13] = 8'h00; hdr[14] = 8'h45; hdr[15] = 8'h00;
    hdr[16] = tl[15:8]; hdr[17] = tl[7:0];
    hdr[18] = ident[15:8]; hdr[19] = ident[7:0];
    hdr[20] = 8'h00; hdr[21] = 8'h00; hdr[22] = 8'h80; hdr[23] = 8'h04;
    hdr[24] = 8'h00; hdr[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      t32 = sip >> (8*i); hdr[26 + i] = t32[7:0];
      t32 = dip >> (8*i); hdr[30 + i] = t32[7:0];
    end
    s = 0;
    for (int k = 0; k < 10; k++) s += {hdr[14 + 2*k], hdr[15 + 2*k]};
    while (s > 32'h0000ffff) s = (s & 32'h0000ffff) + (s >> 16);
    cs = ~s[15:0];
    hdr[24] = cs[15:8]; hdr[25] = cs[7:0];
    exp_q.delete();
    for (int i = 0; i < 34; i++) exp_q.push_back(hdr[i]);
    foreach (msg_q[j]) exp_q.push_back(msg_q[j]);
    for (int j = msg_q.size(); j < p; j++) exp_q.push_back(8'h00);
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ident = 16'h0000; exp_ident_b = 16'h0000;
  endtask

  task automatic set_fixed();
    smac = 48'h54b00bedabba; sip = 32'hbeefbeef;
    dmac = 48'h32dabbadebd5; dip = 32'hdeadbeef;
    msg_q.delete(); msg_q.push_back(8'h01); msg_q.push_back(8'hff);
    msg_a = {msg_q[0], msg_q[1]};
  endtask

  task automatic rand_addrs();
    smac = {16'($urandom), $urandom}; sip = $urandom;
    dmac = {16'($urandom), $urandom}; dip = $urandom;
  endtask

  task automatic rand_msg_a();
    msg_q.delete();
    for (int j = 0; j < 2; j++) msg_q.push_back(8'($urandom));
    msg_a = {msg_q[0], msg_q[1]};
  endtask

  task automatic rand_msg_b();
    msg_q.delete();
    for (int j = 0; j < 40; j++) msg_q.push_back(8'($urandom));
    for (int j = 0; j < 40; j++) msg_b[(39 - j)*8 +: 8] = msg_q[j];
  endtask

  // Runs one frame on dut_a from a negedge with the block idle.
  // mode 0: READY=1; 1: stalls before bytes 4,5,6,7,20,33; 2: random READY.
  task automatic run_frame_a(input int mode, input int inject);
    int cyc, nb, stall_left;
    bit stalled[64];
    bit held_v;
    logic [8:0] held;
    got_q.delete();
    r_lat = -1; r_lasts = 0; r_last_pos = -1; r_stall_err = 0; r_done = 1'b0;
    start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    r_rfs_busy = rfs_a;
    if (inject != 0) begin rand_addrs(); msg_a = 16'($urandom); end
    cyc = 1; nb = 0; stall_left = 0; held_v = 1'b0; held = '0;
    while (!r_done && cyc < 500) begin
      if (valid_a && r_lat < 0) r_lat = cyc;
      if (held_v && (!valid_a || {last_a, data_a} !== held)) r_stall_err++;
      held_v = 1'b0;
      case (mode)
        0: ready_a = 1'b1;
        1: begin
          if (stall_left == 0 && valid_a && nb < 64 && !stalled[nb] &&
              (nb == 4 || nb == 5 || nb == 6 || nb == 7 || nb == 20 || nb == 33)) begin
            stalled[nb] = 1'b1;
            stall_left = $urandom_range(1, 6);
          end
          if (stall_left > 0) begin ready_a = 1'b0; stall_left--; end
          else ready_a = 1'b1;
        end
        default: ready_a = ($urandom_range(0, 3) != 0);
      endcase
      start_a = (inject != 0 && nb >= 10 && nb < 13);
      if (valid_a && ready_a) begin
        got_q.push_back(data_a);
        if (last_a) begin r_lasts++; r_last_pos = nb; r_done = 1'b1; end
        nb++;
      end else if (valid_a) begin
        held = {last_a, data_a}; held_v = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    r_beats = nb; r_rfs_after = rfs_a; r_valid_after = valid_a;
`ifdef IP_TX_IDENT_COUNTER_EN
    if (r_done) exp_ident = exp_ident + 16'd1;
`endif
  endtask

  // Runs one frame on dut_b (4 lanes); mode 0 READY=1, else random READY.
  task automatic run_frame_b(input int mode);
    int cyc, nb;
    bit held_v;
    logic [36:0] held;
    got_q.delete();
    r_lat = -1; r_stall_err = 0; r_keep_err = 0; r_done = 1'b0;
    r_last_keep = '0; r_last_upper = '0;
    start_b = 1'b1; ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1; nb = 0; held_v = 1'b0; held = '0;
    while (!r_done && cyc < 500) begin
      if (valid_b && r_lat < 0) r_lat = cyc;
      if (held_v && (!valid_b || {last_b, keep_b, data_b} !== held)) r_stall_err++;
      held_v = 1'b0;
      ready_b = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (valid_b && ready_b) begin
        for (int k = 0; k < 4; k++) begin
          if (keep_b[k]) got_q.push_back(data_b[8*k +: 8]);
          else if (data_b[8*k +: 8] !== 8'h00) r_keep_err++;
        end
        if (last_b) begin
          r_last_keep = keep_b; r_last_upper = data_b[31:16]; r_done = 1'b1;
        end else if (keep_b !== 4'hf) r_keep_err++;
        nb++;
      end else if (valid_b) begin
        held = {last_b, keep_b, data_b}; held_v = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    r_beats = nb;
`ifdef IP_TX_IDENT_COUNTER_EN
    if (r_done) exp_ident_b = exp_ident_b + 16'd1;
`endif
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rfs_a !== 1'b1) $display("FAIL reset_rfs_a: got %b, required 1", rfs_a); else passed++;
    total++; if (valid_a !== 1'b0) $display("FAIL reset_valid_a: got %b, required 0", valid_a); else passed++;
    total++; if (last_a !== 1'b0) $display("FAIL reset_last_a: got %b, required 0", last_a); else passed++;
    total++; if (tuser_a !== 1'b0) $display("FAIL reset_tuser_a: got %b, required 0", tuser_a); else passed++;
    total++; if (data_a !== 8'h00) $display("FAIL reset_data_a: got %h, required 00", data_a); else passed++;
    total++; if (keep_a !== 1'b0) $display("FAIL reset_keep_a: got %b, required 0", keep_a); else passed++;
    total++; if ({rfs_b, valid_b, last_b, tuser_b} !== 4'b1000)
      $display("FAIL reset_ctrl_b: got %b, required 1000", {rfs_b, valid_b, last_b, tuser_b}); else passed++;
    total++; if ({keep_b, data_b} !== 36'h0)
      $display("FAIL reset_beat_b: got %h, required 0", {keep_b, data_b}); else passed++;
    rst = 1'b0;
    exp_ident = 16'h0000; exp_ident_b = 16'h0000;
  endtask

  task automatic test_basic();
    int d, nz;
    set_fixed();
    build_expected(exp_ident);
    run_frame_a(0, 0);
    total++; if (r_done !== 1'b1) $display("FAIL basic_timeout: got %b, required 1", r_done); else passed++;
    total++; if (r_rfs_busy !== 1'b0) $display("FAIL basic_rfs_busy: got %b, required 0", r_rfs_busy); else passed++;
    total++; if (r_lat != 14) $display("FAIL basic_latency: got %0d, required 14", r_lat); else passed++;
    total++; if (r_beats != 60) $display("FAIL basic_beats: got %0d, required 60", r_beats); else passed++;
    d = first_diff();
    total++; if (d != -1) $display("FAIL basic_bytes: first differing byte %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size()); else passed++;
    total++; if ({got_q[16], got_q[17]} !== 16'h002e) $display("FAIL basic_len: got %h, required 002e", {got_q[16], got_q[17]}); else passed++;
    total++; if ({got_q[24], got_q[25]} !== 16'hbdb1) $display("FAIL basic_csum: got %h, required bdb1", {got_q[24], got_q[25]}); else passed++;
    total++; if ({got_q[34], got_q[35]} !== 16'h01ff) $display("FAIL basic_msg: got %h, required 01ff", {got_q[34], got_q[35]}); else passed++;
    nz = 0;
    for (int i = 36; i < got_q.size(); i++) if (got_q[i] !== 8'h00) nz++;
    total++; if (nz != 0) $display("FAIL basic_pad: got %0d nonzero pad bytes, required 0", nz); else passed++;
    total++; if (r_lasts != 1 || r_last_pos != 59) $display("FAIL basic_last: got %0d lasts at %0d, required 1 at 59", r_lasts, r_last_pos); else passed++;
    total++; if ({r_rfs_after, r_valid_after} !== 2'b10) $display("FAIL basic_idle_after: got %b, required 10", {r_rfs_after, r_valid_after}); else passed++;
  endtask

  task automatic test_stall();
    int d;
    set_fixed();
    build_expected(exp_ident);
    run_frame_a(1, 0);
    total++; if (r_done !== 1'b1 || r_beats != 60) $display("FAIL stall_beats: got %0d, required 60", r_beats); else passed++;
    d = first_diff();
    total++; if (d != -1) $display("FAIL stall_bytes: first differing byte %0d", d); else passed++;
    total++; if (r_stall_err != 0) $display("FAIL stall_hold: got %0d unstable stalls, required 0", r_stall_err); else passed++;
  endtask

  task automatic test_wide();
    int d;
    set_fixed();
    rand_msg_b();
    build_expected(exp_ident_b);
    run_frame_b(0);
    total++; if (r_done !== 1'b1 || r_beats != 19) $display("FAIL wide_beats: got %0d, required 19", r_beats); else passed++;
    total++; if (r_lat != 14) $display("FAIL wide_latency: got %0d, required 14", r_lat); else passed++;
    d = first_diff();
    total++; if (d != -1) $display("FAIL wide_bytes: first differing byte %0d", d); else passed++;
    total++; if ({got_q[16], got_q[17]} !== 16'h003c) $display("FAIL wide_len: got %h, required 003c", {got_q[16], got_q[17]}); else passed++;
    total++; if (r_last_keep !== 4'b0011) $display("FAIL wide_last_keep: got %b, required 0011", r_last_keep); else passed++;
    total++; if (r_last_upper !== 16'h0000) $display("FAIL wide_last_upper: got %h, required 0000", r_last_upper); else passed++;
    total++; if (r_keep_err != 0) $display("FAIL wide_keep: got %0d keep errors, required 0", r_keep_err); else passed++;
    for (int n = 0; n < 3; n++) begin
      rand_addrs(); rand_msg_b();
      build_expected(exp_ident_b);
      run_frame_b(1);
      d = first_diff();
      total++; if (r_done !== 1'b1 || d != -1) $display("FAIL wide_random_%0d: done %b first differing byte %0d", n, r_done, d); else passed++;
      total++; if (r_stall_err != 0 || r_keep_err != 0) $display("FAIL wide_random_hold_%0d: got %0d/%0d errors, required 0", n, r_stall_err, r_keep_err); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [15:0] want_id, want_cs;
`ifdef IP_TX_IDENT_COUNTER_EN
    want_id = 16'h0001; want_cs = 16'hbdb0;
`else
    want_id = 16'h0000; want_cs = 16'hbdb1;
`endif
    do_reset();
    set_fixed();
    build_expected(exp_ident);
    run_frame_a(0, 0);
    d = first_diff();
    total++; if (r_done !== 1'b1 || d != -1) $display("FAIL b2b_first: first differing byte %0d", d); else passed++;
    build_expected(exp_ident);
    run_frame_a(0, 0);
    d = first_diff();
    total++; if (r_done !== 1'b1 || d != -1) $display("FAIL b2b_second: first differing byte %0d", d); else passed++;
    total++; if (r_lat != 14) $display("FAIL b2b_latency: got %0d, required 14", r_lat); else passed++;
    total++; if ({got_q[18], got_q[19]} !== want_id) $display("FAIL b2b_ident: got %h, required %h", {got_q[18], got_q[19]}, want_id); else passed++;
    total++; if ({got_q[24], got_q[25]} !== want_cs) $display("FAIL b2b_csum: got %h, required %h", {got_q[24], got_q[25]}, want_cs); else passed++;
  endtask

  task automatic test_ignored_start();
    int d, extra;
    rand_addrs(); rand_msg_a();
    build_expected(exp_ident);
    run_frame_a(2, 1);
    d = first_diff();
    total++; if (r_done !== 1'b1 || d != -1) $display("FAIL ignored_start_frame: first differing byte %0d", d); else passed++;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      ready_a = 1'b1;
      if (valid_a || !rfs_a) extra++;
      @(negedge clk);
    end
    total++; if (extra != 0) $display("FAIL ignored_start_second: got %0d busy cycles, required 0", extra); else passed++;
  endtask

  task automatic test_reset_abort();
    int nb, cyc, d;
    rand_addrs(); rand_msg_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; ready_a = 1'b1;
    nb = 0; cyc = 0;
    while (nb < 10 && cyc < 200) begin
      if (valid_a && ready_a) nb++;
      @(negedge clk);
      cyc++;
    end
    total++; if (nb != 10) $display("FAIL abort_reach_beat: got %0d beats, required 10", nb); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({valid_a, last_a, rfs_a} !== 3'b001) $display("FAIL abort_state: got %b, required 001", {valid_a, last_a, rfs_a}); else passed++;
    rst = 1'b0;
    exp_ident = 16'h0000; exp_ident_b = 16'h0000;
    build_expected(exp_ident);
    run_frame_a(2, 0);
    d = first_diff();
    total++; if (r_done !== 1'b1 || d != -1) $display("FAIL abort_next_frame: first differing byte %0d", d); else passed++;
    total++; if ({got_q[18], got_q[19]} !== 16'h0000) $display("FAIL abort_ident: got %h, required 0000", {got_q[18], got_q[19]}); else passed++;
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 5; n++) begin
      rand_addrs(); rand_msg_a();
      build_expected(exp_ident);
      run_frame_a(2, 0);
      d = first_diff();
      total++; if (r_done !== 1'b1 || d != -1) $display("FAIL random_frame_%0d: first differing byte %0d", n, d); else passed++;
      total++; if (r_stall_err != 0) $display("FAIL random_hold_%0d: got %0d, required 0", n, r_stall_err); else passed++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    sip = '0; dip = '0; smac = '0; dmac = '0; msg_a = '0; msg_b = '0;
    exp_ident = '0; exp_ident_b = '0;
    test_reset();
    test_basic();
    test_stall();
    test_wide();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ip_packet_tx_wide.md
# ip_packet_tx_wide

Parametrised successor to the byte-serial IPv4 transmitter. It builds one Ethernet II + IPv4 frame per request from the accelerator: MAC header, IP header with a sequentially computed checksum, the message, and zero padding up to the 60-byte minimum frame. It streams the frame to the MAC over a ready/valid interface `DATA_BYTES` wide, with byte-enable keep. It sits between the accelerator core and the MAC TX stream.

## Interface
- `DATA_BYTES`, 1: MAC stream width in bytes; legal values 1, 2, 4, 8.
- `PAYLOAD_BYTES`, 2: message length in bytes; legal range 1..1480.
- `ACLK` in 1: single clock; everything is on the rising edge.
- `ARESET` in 1: reset, synchronous, active-high.
- `ACCELERATOR_IP_ADDRESS` in 32: source IP address.
- `ACCELERATOR_MAC_ADDRESS` in 48: source MAC address.
- `RECIPIENT_IP_ADDRESS` in 32: destination IP address.
- `RECIPIENT_MAC_ADDRESS` in 48: destination MAC address.
- `RECIPIENT_MESSAGE` in `PAYLOAD_BYTES*8`: payload, transmitted most-significant byte first.
- `START_IP_TXN` in 1: request pulse; honoured only while `READY_FOR_SEND`=1.
- `READY_FOR_SEND` out 1: block is idle and can accept a request.
- `MAC_DATA_OUT` out `DATA_BYTES*8`: beat data; lane k is bits [8k+7:8k].
- `MAC_DATA_KEEP` out `DATA_BYTES`: lane valid mask.
- `MAC_DATA_READY` in 1: MAC accepts the beat.
- `MAC_DATA_VALID` out 1: beat valid.
- `MAC_DATA_LAST` out 1: final beat of the frame.
- `MAC_DATA_TUSER` out 1: tied to 0.

## Operation
- Padded payload: P = max(`PAYLOAD_BYTES`, 26).
- Frame length: F = 34 + P.
- IP total length field: 20 + P.

Frame byte order (index from 0):
- 0–5: destination MAC, least-significant byte first.
- 6–11: source MAC, least-significant byte first.
- 12–13: 0x80, 0x00.
- 14: 0x45.
- 15: 0x00.
- 16–17: total length, big-endian.
- 18–19: identification, big-endian.
- 20–21: 0x0000 (flags/fragment).
- 22: TTL 0x80.
- 23: protocol 0x04.
- 24–25: checksum, big-endian.
- 26–29: source IP, least-significant byte first.
- 30–33: destination IP, least-significant byte first.
- 34 onward: message bytes, then zero padding.

Checksum:
- Ones'-complement sum of header bytes 14..33, taken as big-endian 16-bit pairs (2k, 2k+1), with the checksum field counted as 0.
- Carries are folded end-around, and the result is inverted.

Beat packing:
- Frame byte i goes to beat i/`DATA_BYTES`, lane i%`DATA_BYTES`.
- `MAC_DATA_KEEP` is all-ones except on the last beat, where it covers the low (F%`DATA_BYTES`) lanes. If that remainder is 0, the last beat is all-ones.
- Lanes with keep=0 carry 0.

State machine:
- IDLE → LATCH: `START_IP_TXN`=1 is sampled. All address and message inputs are registered, so later input changes do not affect the frame.
- LATCH → CSUM: unconditional, next cycle.
- CSUM: adds one header word per cycle for 10 cycles.
- FOLD: one cycle; folds carries and inverts.
- SEND: presents beats. Leaves after the handshake (VALID & READY) on the LAST beat.
- SEND → IDLE: `READY_FOR_SEND` returns to 1 on the cycle after the final handshake.

Boundary conditions:
- `START_IP_TXN` outside IDLE is ignored, not queued.
- `ARESET` in any state returns to IDLE on the next edge, aborting the frame with no LAST. The MAC side is responsible for the truncated frame.

## Timing
- Reset values:
  - `READY_FOR_SEND`=1.
  - `MAC_DATA_VALID`=0, `MAC_DATA_LAST`=0, `MAC_DATA_TUSER`=0.
  - `MAC_DATA_OUT`=0, `MAC_DATA_KEEP`=0.
  - Identification counter = 0.
- Start handshake: `START_IP_TXN` sampled at edge 0 → `READY_FOR_SEND`=0 after edge 0. LATCH at edge 1, CSUM at edges 2–11, FOLD at edge 12, first `MAC_DATA_VALID`=1 after edge 13.
- VALID, DATA, KEEP and LAST hold stable while VALID=1 and READY=0.
- VALID never drops mid-frame.
- With READY held at 1, one beat transfers per cycle and there are no bubbles.
- Identification increments by 1 (mod 2^16) on the final handshake of each frame.

## Configuration
- `IP_TX_IDENT_COUNTER_EN` defined: the identification field is the per-frame counter.
- `IP_TX_IDENT_COUNTER_EN` undefined: the identification field is constant 0x0000 and the counter is not built.

## Structure
- Package `ip_tx_pkg` holds:
  - Constants: `ETH_TYPE`=16'h8000, `IP_VERSION_IHL`=8'h45, `IP_TTL`=8'h80, `IP_PROTOCOL`=8'h04.
  - Sizes: `ETH_HDR_BYTES`=14, `IP_HDR_BYTES`=20, `MIN_FRAME_BYTES`=60.
  - The state enum typedef.
- Sub-module `ip_header_checksum_seq` is the natural split: a 32-bit accumulator fed one 16-bit word per cycle, plus fold/invert and a done flag.

## Test plan
Common setup for scenarios 1–4:
- Source MAC 0x54b00bedabba, source IP 0xbeefbeef.
- Destination MAC 0x32dabbadebd5, destination IP 0xdeadbeef.
- Message 0x01ff.

Scenarios:
1. `DATA_BYTES`=1, `PAYLOAD_BYTES`=2, READY held at 1 → 60 beats; bytes 16–17 = 00 2E; checksum bytes BD B1; bytes 34–35 = 01 FF; bytes 36–59 = 00; LAST on beat 59 only.
2. Same configuration, READY dropped for 1–6 cycles before frame bytes 4, 5, 6, 7, 20 and 33 → identical byte sequence; VALID stays 1 and data stays stable during each stall.
3. `DATA_BYTES`=4, `PAYLOAD_BYTES`=40 → 19 beats; length field 0x003C; beat 18 has KEEP=4'b0011 and upper lanes 0.
4. `IP_TX_IDENT_COUNTER_EN` defined, two back-to-back frames with scenario 1 inputs → second frame has identification 0x0001 and checksum BD B0. With the macro undefined, both frames have checksum BD B1.
5. `START_IP_TXN` pulsed mid-frame and inputs changed after the accepted start → no second frame; the first frame is unchanged.
6. `ARESET` asserted at beat 10 → next cycle VALID=0, `READY_FOR_SEND`=1, identification reset to 0; a new start then produces a complete frame.
